// File: rtl/shf_pkg.sv
// Shared types and pipeline-placement helpers for the alignment/normalisation shifter.
package shf_pkg;

    typedef enum logic [1:0] {
        SHF_SRL = 2'b00,
        SHF_SRA = 2'b01,
        SHF_SLL = 2'b10,
        SHF_RSV = 2'b11
    } shf_mode_e;

    // Number of shift stages completed before pipeline register j (j = 0 gives 0).
    function automatic int stage_boundary(input int j, input int size_shift, input int num_pipe);
        return (j * size_shift + num_pipe - 1) / num_pipe;
    endfunction

    // Index of the pipeline segment (0-based) that contains shift stage s.
    function automatic int segment_of(input int s, input int size_shift, input int num_pipe);
        int seg;
        seg = 0;
        for (int k = 1; k < num_pipe; k++) begin
            if (stage_boundary(k, size_shift, num_pipe) <= s) begin
                seg = k;
            end
        end
        return seg;
    endfunction

endpackage

// File: rtl/shf_stage.sv
// One binary shift stage: shifts by SHIFT_VAL when enabled and folds discarded
// bits into the running sticky (right shifts) or overflow (left shift) flag.
module shf_stage
    import shf_pkg::*;
#(
    parameter int SIZE_DATA = 27,
    parameter int SHIFT_VAL = 1
) (
    input  logic [SIZE_DATA-1:0] data_in,
    input  logic                 enable,
    input  shf_mode_e            mode,
    input  logic                 sign,
    input  logic                 sticky_in,
    input  logic                 ovf_in,
    output logic [SIZE_DATA-1:0] data_out,
    output logic                 sticky_out,
    output logic                 ovf_out
);

    logic                 fill;
    logic [SIZE_DATA-1:0] right_res;
    logic [SIZE_DATA-1:0] left_res;
    logic                 right_lost;
    logic                 left_lost;

    assign fill = (mode == SHF_SRA) & sign;

    generate
        if (SHIFT_VAL >= SIZE_DATA) begin : g_whole
            // The whole word falls off the end.
            assign right_res  = {SIZE_DATA{fill}};
            assign left_res   = '0;
            assign right_lost = |data_in;
            assign left_lost  = |data_in;
        end else begin : g_part
            assign right_res  = {{SHIFT_VAL{fill}}, data_in[SIZE_DATA-1:SHIFT_VAL]};
            assign left_res   = {data_in[SIZE_DATA-SHIFT_VAL-1:0], {SHIFT_VAL{1'b0}}};
            assign right_lost = |data_in[SHIFT_VAL-1:0];
            assign left_lost  = |data_in[SIZE_DATA-1:SIZE_DATA-SHIFT_VAL];
        end
    endgenerate

    always_comb begin
        data_out   = data_in;
        sticky_out = sticky_in;
        ovf_out    = ovf_in;
        if (enable) begin
            if (mode == SHF_SLL) begin
                data_out = left_res;
                ovf_out  = ovf_in | left_lost;
            end else begin
                data_out   = right_res;
                sticky_out = sticky_in | right_lost;
            end
        end
    end

endmodule

// File: rtl/shf_align_pipe.sv
// Pipelined barrel shifter (SRL/SRA/SLL) with sticky/overflow flags, tag sideband
// and a valid/ready handshake whose ready ripples combinationally back from i_ready.
module shf_align_pipe
    import shf_pkg::*;
#(
    parameter int SIZE_DATA  = 27,
    parameter int SIZE_SHIFT = 5,
    parameter int NUM_PIPE   = 2,
    parameter int SIZE_TAG   = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  shf_mode_e             i_mode,
    input  logic [SIZE_SHIFT-1:0] i_shift_number,
    input  logic [SIZE_DATA-1:0]  i_data,
    input  logic [SIZE_TAG-1:0]   i_tag,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [SIZE_DATA-1:0]  o_data,
    output logic                  o_sticky,
    output logic                  o_ovf,
    output logic [SIZE_TAG-1:0]   o_tag
);

    // Segment g is the group of stages feeding register g; its source is the
    // input port for g = 0 and register g-1 otherwise.
    logic                  seg_valid  [NUM_PIPE];
    logic [SIZE_DATA-1:0]  seg_data   [NUM_PIPE];
    logic                  seg_sticky [NUM_PIPE];
    logic                  seg_ovf    [NUM_PIPE];
    shf_mode_e             seg_mode   [NUM_PIPE];
    logic                  seg_sign   [NUM_PIPE];
    logic [SIZE_SHIFT-1:0] seg_shamt  [NUM_PIPE];
    logic [SIZE_TAG-1:0]   seg_tag    [NUM_PIPE];

    logic                  r_valid  [NUM_PIPE];
    logic [SIZE_DATA-1:0]  r_data   [NUM_PIPE];
    logic                  r_sticky [NUM_PIPE];
    logic                  r_ovf    [NUM_PIPE];
    shf_mode_e             r_mode   [NUM_PIPE];
    logic                  r_sign   [NUM_PIPE];
    logic [SIZE_SHIFT-1:0] r_shamt  [NUM_PIPE];
    logic [SIZE_TAG-1:0]   r_tag    [NUM_PIPE];

    logic [SIZE_DATA-1:0]  stg_data   [SIZE_SHIFT];
    logic                  stg_sticky [SIZE_SHIFT];
    logic                  stg_ovf    [SIZE_SHIFT];

    logic                  ready [NUM_PIPE+1];

    assign seg_valid[0]  = i_valid;
    assign seg_data[0]   = i_data;
    assign seg_sticky[0] = 1'b0;
    assign seg_ovf[0]    = 1'b0;
    assign seg_mode[0]   = i_mode;
    assign seg_sign[0]   = (i_mode == SHF_SRA) & i_data[SIZE_DATA-1];
    assign seg_shamt[0]  = i_shift_number;
    assign seg_tag[0]    = i_tag;

    assign ready[NUM_PIPE] = i_ready;

    genvar gi;
    generate
        for (gi = 1; gi < NUM_PIPE; gi++) begin : g_seg
            assign seg_valid[gi]  = r_valid[gi-1];
            assign seg_data[gi]   = r_data[gi-1];
            assign seg_sticky[gi] = r_sticky[gi-1];
            assign seg_ovf[gi]    = r_ovf[gi-1];
            assign seg_mode[gi]   = r_mode[gi-1];
            assign seg_sign[gi]   = r_sign[gi-1];
            assign seg_shamt[gi]  = r_shamt[gi-1];
            assign seg_tag[gi]    = r_tag[gi-1];
        end

        for (gi = 0; gi < SIZE_SHIFT; gi++) begin : g_stage
            localparam int SEG = segment_of(gi, SIZE_SHIFT, NUM_PIPE);
            logic [SIZE_DATA-1:0] d_in;
            logic                 st_in;
            logic                 ov_in;

            if (gi == stage_boundary(SEG, SIZE_SHIFT, NUM_PIPE)) begin : g_head
                assign d_in  = seg_data[SEG];
                assign st_in = seg_sticky[SEG];
                assign ov_in = seg_ovf[SEG];
            end else begin : g_body
                assign d_in  = stg_data[gi-1];
                assign st_in = stg_sticky[gi-1];
                assign ov_in = stg_ovf[gi-1];
            end

            shf_stage #(
                .SIZE_DATA (SIZE_DATA),
                .SHIFT_VAL (1 << gi)
            ) u_stage (
                .data_in    (d_in),
                .enable     (seg_shamt[SEG][gi]),
                .mode       (seg_mode[SEG]),
                .sign       (seg_sign[SEG]),
                .sticky_in  (st_in),
                .ovf_in     (ov_in),
                .data_out   (stg_data[gi]),
                .sticky_out (stg_sticky[gi]),
                .ovf_out    (stg_ovf[gi])
            );
        end

        for (gi = 0; gi < NUM_PIPE; gi++) begin : g_reg
            localparam int LAST_STAGE = stage_boundary(gi + 1, SIZE_SHIFT, NUM_PIPE) - 1;
            logic                  valid_q,  valid_d;
            logic [SIZE_DATA-1:0]  data_q,   data_d;
            logic                  sticky_q, sticky_d;
            logic                  ovf_q,    ovf_d;
            shf_mode_e             mode_q,   mode_d;
            logic                  sign_q,   sign_d;
            logic [SIZE_SHIFT-1:0] shamt_q,  shamt_d;
            logic [SIZE_TAG-1:0]   tag_q,    tag_d;

            // An empty register always loads, so bubbles collapse under backpressure.
            assign ready[gi] = ~valid_q | ready[gi+1];

            always_comb begin
                valid_d  = valid_q;
                data_d   = data_q;
                sticky_d = sticky_q;
                ovf_d    = ovf_q;
                mode_d   = mode_q;
                sign_d   = sign_q;
                shamt_d  = shamt_q;
                tag_d    = tag_q;
                if (ready[gi]) begin
                    valid_d = seg_valid[gi];
                    if (seg_valid[gi]) begin
                        data_d   = stg_data[LAST_STAGE];
                        sticky_d = stg_sticky[LAST_STAGE];
                        ovf_d    = stg_ovf[LAST_STAGE];
                        mode_d   = seg_mode[gi];
                        sign_d   = seg_sign[gi];
                        shamt_d  = seg_shamt[gi];
                        tag_d    = seg_tag[gi];
                    end
                end
            end

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    valid_q  <= 1'b0;
                    data_q   <= '0;
                    sticky_q <= 1'b0;
                    ovf_q    <= 1'b0;
                    mode_q   <= SHF_SRL;
                    sign_q   <= 1'b0;
                    shamt_q  <= '0;
                    tag_q    <= '0;
                end else begin
                    valid_q  <= valid_d;
                    data_q   <= data_d;
                    sticky_q <= sticky_d;
                    ovf_q    <= ovf_d;
                    mode_q   <= mode_d;
                    sign_q   <= sign_d;
                    shamt_q  <= shamt_d;
                    tag_q    <= tag_d;
                end
            end

            assign r_valid[gi]  = valid_q;
            assign r_data[gi]   = data_q;
            assign r_sticky[gi] = sticky_q;
            assign r_ovf[gi]    = ovf_q;
            assign r_mode[gi]   = mode_q;
            assign r_sign[gi]   = sign_q;
            assign r_shamt[gi]  = shamt_q;
            assign r_tag[gi]    = tag_q;
        end
    endgenerate

    assign o_ready  = ready[0];
    assign o_valid  = r_valid[NUM_PIPE-1];
    assign o_data   = r_data[NUM_PIPE-1];
    assign o_sticky = r_sticky[NUM_PIPE-1];
    assign o_ovf    = r_ovf[NUM_PIPE-1];
    assign o_tag    = r_tag[NUM_PIPE-1];

endmodule

// File: tb/tb_shf_align_pipe.sv
// Self-checking bench for shf_align_pipe (8-bit data, 4-bit shift, 2 registers)
// against an arithmetic reference model and an in-order scoreboard.
module tb_shf_align_pipe;
    import shf_pkg::*;

    localparam int W  = 8;
    localparam int SS = 4;
    localparam int NP = 2;
    localparam int TW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_valid = 1'b0;
    logic          i_ready = 1'b0;
    shf_mode_e     i_mode = SHF_SRL;
    logic [SS-1:0] i_shift = '0;
    logic [W-1:0]  i_data = '0;
    logic [TW-1:0] i_tag = '0;
    logic          o_ready, o_valid, o_sticky, o_ovf;
    logic [W-1:0]  o_data;
    logic [TW-1:0] o_tag;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [W-1:0]  data;
        logic          sticky;
        logic          ovf;
        logic [TW-1:0] tag;
    } exp_t;

    shf_align_pipe #(.SIZE_DATA(W), .SIZE_SHIFT(SS), .NUM_PIPE(NP), .SIZE_TAG(TW)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_mode(i_mode), .i_shift_number(i_shift), .i_data(i_data), .i_tag(i_tag),
        .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .o_sticky(o_sticky),
        .o_ovf(o_ovf), .o_tag(o_tag)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [1:0] mode, input int amt,
                                   input logic [W-1:0] d, input logic [TW-1:0] tag);
        exp_t e;
        int   dv, res, mask;
        bit   neg;
        dv = int'(d);
        mask = (1 << W) - 1;
        e.tag = tag;
        e.sticky = 1'b0;
        e.ovf = 1'b0;
        if (mode == 2'b10) begin
            if (amt >= W) begin
                res = 0;
                e.ovf = (dv != 0);
            end else begin
                res = (dv << amt) & mask;
                e.ovf = ((dv >> (W - amt)) != 0);
            end
        end else begin
            neg = (mode == 2'b01) && d[W-1];
            if (amt >= W) begin
                res = neg ? mask : 0;
                e.sticky = (dv != 0);
            end else begin
                res = dv >> amt;
                if (neg) res = res | (mask & ~(mask >> amt));
                e.sticky = ((dv & ((1 << amt) - 1)) != 0);
            end
        end
        e.data = res[W-1:0];
        return e;
    endfunction

    task automatic set_beat(input logic [1:0] m, input int amt, input logic [W-1:0] d,
                            input logic [TW-1:0] t);
        i_mode  = shf_mode_e'(m);
        i_shift = amt[SS-1:0];
        i_data  = d;
        i_tag   = t;
    endtask

    // Called at a falling edge: samples handshake state, then advances one cycle.
    task automatic tick(output bit acc, output bit dlv, output exp_t got);
        #1;
        acc = i_valid && o_ready;
        dlv = o_valid && i_ready;
        got.data = o_data;
        got.sticky = o_sticky;
        got.ovf = o_ovf;
        got.tag = o_tag;
        if (dlv) $display("beat out: tag=%0d data=%h sticky=%b ovf=%b", o_tag, o_data, o_sticky, o_ovf);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_single(input logic [1:0] m, input int amt, input logic [W-1:0] d,
                              input logic [TW-1:0] t, output exp_t got, output int lat);
        bit acc, dlv, accepted;
        exp_t g;
        int cnt;
        lat = -1;
        got = '0;
        accepted = 0;
        cnt = 0;
        i_ready = 1'b1;
        i_valid = 1'b1;
        set_beat(m, amt, d, t);
        for (int c = 0; c < 20; c++) begin
            tick(acc, dlv, g);
            if (acc && !accepted) begin
                accepted = 1;
                cnt = 0;
                i_valid = 1'b0;
            end else if (accepted) begin
                cnt++;
            end
            if (accepted && dlv) begin
                got = g;
                lat = cnt;
                break;
            end
        end
        i_valid = 1'b0;
    endtask

    task automatic test_reset;
        #2;
        n_checks++;
        if (o_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid_during: got %b want 0", o_valid); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if ({o_valid, o_data, o_sticky, o_ovf, o_tag} !== '0) begin
            n_fail++;
            $display("FAIL rst_outputs: got valid=%b data=%h sticky=%b ovf=%b tag=%h want all 0",
                     o_valid, o_data, o_sticky, o_ovf, o_tag);
        end
        n_checks++;
        if (o_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b want 1", o_ready); end
        @(negedge clk);
    endtask

    task automatic test_srl;
        exp_t g;
        int lat;
        for (int k = 0; k < 2; k++) begin
            // k = 1 uses the reserved encoding, which must behave exactly as SRL.
            run_single(k == 0 ? 2'b00 : 2'b11, 3, 8'b1011_0110, 4'd5, g, lat);
            n_checks++;
            if (lat !== 2) begin n_fail++; $display("FAIL srl_latency[%0d]: got %0d want 2", k, lat); end
            n_checks++;
            if ({g.data, g.sticky, g.ovf, g.tag} !== {8'h16, 1'b1, 1'b0, 4'd5}) begin
                n_fail++;
                $display("FAIL srl_result[%0d]: got data=%h sticky=%b ovf=%b tag=%0d want data=16 sticky=1 ovf=0 tag=5",
                         k, g.data, g.sticky, g.ovf, g.tag);
            end
        end
    endtask

    task automatic test_sra;
        exp_t g;
        int lat;
        run_single(2'b01, 2, 8'h90, 4'd1, g, lat);
        n_checks++;
        if ({g.data, g.sticky, g.ovf} !== {8'hE4, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL sra_by2: got data=%h sticky=%b ovf=%b want data=e4 sticky=0 ovf=0", g.data, g.sticky, g.ovf);
        end
        run_single(2'b01, 12, 8'h90, 4'd2, g, lat);
        n_checks++;
        if ({g.data, g.sticky, g.ovf} !== {8'hFF, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL sra_by12: got data=%h sticky=%b ovf=%b want data=ff sticky=1 ovf=0", g.data, g.sticky, g.ovf);
        end
    endtask

    task automatic test_sll;
        exp_t g;
        int lat;
        run_single(2'b10, 1, 8'hC3, 4'd3, g, lat);
        n_checks++;
        if ({g.data, g.sticky, g.ovf} !== {8'h86, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL sll_by1: got data=%h sticky=%b ovf=%b want data=86 sticky=0 ovf=1", g.data, g.sticky, g.ovf);
        end
        run_single(2'b10, 6, 8'h03, 4'd4, g, lat);
        n_checks++;
        if ({g.data, g.sticky, g.ovf} !== {8'hC0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL sll_by6: got data=%h sticky=%b ovf=%b want data=c0 sticky=0 ovf=0", g.data, g.sticky, g.ovf);
        end
        run_single(2'b10, 0, 8'hA5, 4'd6, g, lat);
        n_checks++;
        if ({g.data, g.sticky, g.ovf, g.tag} !== {8'hA5, 1'b0, 1'b0, 4'd6}) begin
            n_fail++;
            $display("FAIL sll_by0: got data=%h sticky=%b ovf=%b tag=%0d want data=a5 sticky=0 ovf=0 tag=6",
                     g.data, g.sticky, g.ovf, g.tag);
        end
    endtask

    task automatic test_backpressure;
        logic [1:0]   bm [4];
        int           ba [4];
        logic [W-1:0] bd [4];
        exp_t q[$];
        exp_t g, e;
        logic [W-1:0] held;
        bit acc, dlv;
        int idx, ndl;
        idx = 0;
        ndl = 0;
        held = '0;
        for (int k = 0; k < 4; k++) begin
            bm[k] = 2'($urandom_range(0, 3));
            ba[k] = int'($urandom_range(0, 15));
            bd[k] = 8'($urandom);
        end
        for (int c = 0; c < 40 && ndl < 4; c++) begin
            i_ready = (c >= 7);
            i_valid = (idx < 4);
            if (idx < 4) set_beat(bm[idx], ba[idx], bd[idx], 4'(idx + 1));
            tick(acc, dlv, g);
            if (acc) begin
                q.push_back(model(bm[idx], ba[idx], bd[idx], 4'(idx + 1)));
                idx++;
            end
            if (dlv) begin
                e = q.pop_front();
                n_checks++;
                if (g !== e || g.tag !== 4'(ndl + 1)) begin
                    n_fail++;
                    $display("FAIL bp_beat%0d: got data=%h sticky=%b ovf=%b tag=%0d want data=%h sticky=%b ovf=%b tag=%0d",
                             ndl, g.data, g.sticky, g.ovf, g.tag, e.data, e.sticky, e.ovf, ndl + 1);
                end
                ndl++;
            end
            if (c == 1) held = o_data;
            if (c >= 2 && c <= 5) begin
                n_checks++;
                if ({o_ready, o_valid, o_tag, o_data} !== {1'b0, 1'b1, 4'd1, held}) begin
                    n_fail++;
                    $display("FAIL bp_stall_c%0d: got ready=%b valid=%b tag=%0d data=%h want ready=0 valid=1 tag=1 data=%h",
                             c, o_ready, o_valid, o_tag, o_data, held);
                end
            end
        end
        i_valid = 1'b0;
        n_checks++;
        if (ndl !== 4 || idx !== 4) begin
            n_fail++;
            $display("FAIL bp_count: got accepted=%0d delivered=%0d want 4 and 4", idx, ndl);
        end
    endtask

    task automatic test_throughput;
        exp_t q[$];
        exp_t g, e;
        bit acc, dlv, gap;
        int ndl, first, last;
        logic [1:0] m;
        int a;
        logic [W-1:0] d;
        ndl = 0; first = -1; last = -1; gap = 0;
        i_ready = 1'b1;
        for (int c = 0; c < 16 + NP + 4; c++) begin
            m = 2'($urandom_range(0, 3));
            a = int'($urandom_range(0, 15));
            d = 8'($urandom);
            i_valid = (c < 16);
            set_beat(m, a, d, 4'(c));
            tick(acc, dlv, g);
            if (c < 16 && !acc) gap = 1;
            if (acc) q.push_back(model(m, a, d, 4'(c)));
            if (dlv) begin
                if (first < 0) first = c;
                last = c;
                e = (q.size() > 0) ? q.pop_front() : '0;
                n_checks++;
                if (g !== e) begin
                    n_fail++;
                    $display("FAIL tp_beat%0d: got data=%h sticky=%b ovf=%b tag=%0d want data=%h sticky=%b ovf=%b tag=%0d",
                             ndl, g.data, g.sticky, g.ovf, g.tag, e.data, e.sticky, e.ovf, e.tag);
                end
                ndl++;
            end
        end
        i_valid = 1'b0;
        n_checks++;
        if (gap || ndl !== 16 || first !== NP || last !== NP + 15) begin
            n_fail++;
            $display("FAIL tp_timing: got input_gap=%b delivered=%0d first=%0d last=%0d want 0 16 %0d %0d",
                     gap, ndl, first, last, NP, NP + 15);
        end
    endtask

    task automatic test_random_stall;
        exp_t q[$];
        exp_t g, e;
        bit acc, dlv;
        logic [1:0] m;
        int a;
        logic [W-1:0] d;
        logic [TW-1:0] t;
        int nacc;
        nacc = 0;
        for (int c = 0; c < 120; c++) begin
            m = 2'($urandom_range(0, 3));
            a = int'($urandom_range(0, 15));
            d = 8'($urandom);
            t = 4'($urandom);
            i_valid = (c < 100) && ($urandom_range(0, 3) != 0);
            i_ready = (c >= 100) || ($urandom_range(0, 2) != 0);
            set_beat(m, a, d, t);
            tick(acc, dlv, g);
            if (acc) begin
                q.push_back(model(m, a, d, t));
                nacc++;
            end
            if (dlv) begin
                n_checks++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rnd_extra: got unexpected beat tag=%0d data=%h want none", g.tag, g.data);
                end else begin
                    e = q.pop_front();
                    if (g !== e) begin
                        n_fail++;
                        $display("FAIL rnd_beat: got data=%h sticky=%b ovf=%b tag=%0d want data=%h sticky=%b ovf=%b tag=%0d",
                                 g.data, g.sticky, g.ovf, g.tag, e.data, e.sticky, e.ovf, e.tag);
                    end
                end
            end
        end
        i_valid = 1'b0;
        n_checks++;
        if (q.size() !== 0 || nacc == 0) begin
            n_fail++;
            $display("FAIL rnd_drain: got %0d undelivered of %0d accepted want 0 undelivered", q.size(), nacc);
        end
    endtask

    task automatic test_reset_midflight;
        bit acc, dlv, stale;
        exp_t g;
        int nacc;
        nacc = 0;
        stale = 0;
        i_ready = 1'b0;
        i_valid = 1'b1;
        for (int c = 0; c < 2; c++) begin
            set_beat(2'b00, c, 8'hF0 + 8'(c), 4'(9 + c));
            tick(acc, dlv, g);
            if (acc) nacc++;
        end
        i_valid = 1'b0;
        n_checks++;
        if (nacc !== 2 || o_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_fill: got accepted=%0d valid=%b want 2 and 1", nacc, o_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({o_valid, o_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL mid_async: got valid=%b ready=%b want valid=0 ready=1", o_valid, o_ready);
        end
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(negedge clk);
        i_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick(acc, dlv, g);
            if (dlv) stale = 1;
        end
        n_checks++;
        if (stale || o_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_after: got stale=%b ready=%b want stale=0 ready=1", stale, o_ready);
        end
    endtask

    initial begin
        test_reset();
        test_srl();
        test_sra();
        test_sll();
        test_backpressure();
        test_throughput();
        test_random_stall();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/shf_align_pipe.md
Name: shf_align_pipe

Overview:
- Parametrised, pipelined barrel shifter for the FP datapath, used for mantissa alignment in add/sub and for normalisation.
- Supports logical-right, arithmetic-right and logical-left shifts.
- Produces a sticky bit (OR of bits shifted out on right shifts) and an overflow flag (bits lost on left shifts).
- Carries a sideband tag and uses a valid/ready handshake, so it can sit between FP pipeline stages with backpressure.

Parameters:
- SIZE_DATA, 27, data width in bits (mantissa plus G/R/S).
- SIZE_SHIFT, 5, shift-amount width; the shifter has SIZE_SHIFT binary stages.
- NUM_PIPE, 2, number of pipeline registers, 1..SIZE_SHIFT; equals the latency in cycles.
- SIZE_TAG, 4, sideband tag width; must be ≥1.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_valid  in  1  input beat valid.
- o_ready  out  1  block can accept a beat this cycle.
- i_mode  in  2  shf_mode_e: 00 SRL, 01 SRA, 10 SLL, 11 reserved (treated as SRL).
- i_shift_number  in  SIZE_SHIFT  shift amount.
- i_data  in  SIZE_DATA  operand.
- i_tag  in  SIZE_TAG  sideband, passed through unchanged.
- o_valid  out  1  output beat valid.
- i_ready  in  1  downstream accepts the output.
- o_data  out  SIZE_DATA  shifted result.
- o_sticky  out  1  right shifts: OR of all discarded bits; 0 for SLL.
- o_ovf  out  1  SLL: OR of all bits shifted out of the MSB; 0 for right shifts.
- o_tag  out  SIZE_TAG  tag of the output beat.

Behaviour:
- Clock and reset: one clock domain. i_rst_n is asynchronous and active-low. On reset, all stage valids, o_valid, o_data, o_sticky, o_ovf and o_tag are cleared to 0; o_ready is 1 in the first cycle after reset deassertion.
- Shift stages: stage i shifts by 2^i when i_shift_number[i] is set.
  - SRL fills with 0; SRA fills with the operand MSB captured at input; SLL fills the LSBs with 0.
  - Each stage ORs its discarded bits into a running sticky (right modes) or running ovf (SLL).
  - If 2^i ≥ SIZE_DATA, the stage discards the whole word: result is all fill bits and sticky/ovf |= OR(word).
- Pipeline registers: register j (1..NUM_PIPE) sits after stage ceil(j*SIZE_SHIFT/NUM_PIPE). The last register drives the outputs directly.
- Registered fields: each register holds valid, data, sticky, ovf, mode, sign fill and tag.
- Latency and throughput: latency is exactly NUM_PIPE cycles from input handshake to o_valid with no stalls; throughput is 1 beat/cycle.
- Handshake:
  - A beat is accepted when i_valid && o_ready.
  - A beat is delivered when o_valid && i_ready.
  - Register j loads when it is empty or when register j+1 loads this cycle (for the last register: when i_ready is high). ready_j = ~valid_j | ready_{j+1}.
  - o_ready = ready_1, a combinational chain; no skid buffer.
  - While o_valid && !i_ready, o_data, o_sticky, o_ovf and o_tag hold stable.
  - Bubbles collapse: an empty register loads even when downstream is stalled.
- Pipe full with i_ready=0: o_ready=0 and i_valid is ignored. Full pipe with i_ready=1 accepts a new beat and delivers one in the same cycle.
- Shift amount 0: o_data = i_data, sticky = 0, ovf = 0.
- Amount ≥ SIZE_DATA (reachable when 2^SIZE_SHIFT > SIZE_DATA):
  - SRL result 0; SRA result all sign bits; SLL result 0.
  - sticky/ovf = OR of all input bits; for SRA, sticky = OR of all input bits as well.
- Reset mid-operation: all in-flight beats are dropped and no partial output is produced.
- i_mode=11 behaves exactly as SRL.

Decomposition:
- Package shf_pkg:
  - typedef enum logic [1:0] shf_mode_e {SHF_SRL, SHF_SRA, SHF_SLL, SHF_RSV}.
  - Function computing register placement stage indices from SIZE_SHIFT and NUM_PIPE.
- Sub-module shf_stage (combinational, params SIZE_DATA, SHIFT_VAL):
  - Inputs: data, enable, mode, sign, sticky_in, ovf_in.
  - Outputs: data, sticky_out, ovf_out.
- Top module generates SIZE_SHIFT shf_stage instances and NUM_PIPE handshake registers.

Test Plan (test config SIZE_DATA=8, SIZE_SHIFT=4, NUM_PIPE=2, SIZE_TAG=4 unless noted):
- SRL data=8'b1011_0110, shift=3, tag=5, i_ready=1 -> after 2 cycles o_data=8'b0001_0110, o_sticky=1, o_ovf=0, o_tag=5.
- SRA data=8'h90, shift=2 -> o_data=8'hE4, sticky=0. Then SRA data=8'h90, shift=12 -> o_data=8'hFF, sticky=1.
- SLL data=8'hC3, shift=1 -> o_data=8'h86, ovf=1. Then SLL data=8'h03, shift=6 -> o_data=8'hC0, ovf=0. Then shift=0 -> data unchanged, sticky=0, ovf=0.
- Backpressure: stream 4 beats with tags 1..4, hold i_ready=0 from cycle 2 -> o_ready drops after 2 beats held and o_data holds stable. Release i_ready -> tags emerge 1,2,3,4 in order with no loss or duplication.
- Full throughput: 16 back-to-back random beats with i_ready=1 -> one output per cycle, first at cycle 2, all matching the reference model.
- Reset mid-flight: 2 beats in the pipe, pulse i_rst_n low asynchronously between clock edges -> o_valid=0 immediately, no stale beat after release, o_ready=1.
